segment_labeler: RTL and testbench

SEGMENT_LABELER -- requirements
Module: segment_labeler

---
 rtl/segment_labeler.sv | 147 ++++++++++++++
 tb/tb_segment_labeler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/segment_labeler.sv
// segment_labeler: RGB -> luma -> class label with per-frame thresholds
// and a per-frame class histogram snapshot.
//
// Ports:
//   clock, n_rst        : clock, async active-low reset
//   in_y                : pixel {R,G,B}
//   in_hcnt, in_vcnt    : signed pixel coords, negative = blanking
//   cfg_we/idx/thr      : shadow threshold write (idx 0 ignored)
//   hist_sel            : histogram class select
//   out_y               : pixel label, 3 cycles after input
//   out_hcnt, out_vcnt  : coords aligned with out_y
//   hist_cnt            : snapshot count of class hist_sel
//   frame_done          : pulse when (0,0) reaches the output
module segment_labeler #(
  parameter int CH_W    = 8,
  parameter int H_W     = 10,
  parameter int V_W     = 9,
  parameter int LABEL_W = 2,
  parameter int CNT_W   = 20
) (
  input  logic                      clock,
  input  logic                      n_rst,
  input  logic [3*CH_W-1:0]         in_y,
  input  logic signed [H_W-1:0]     in_hcnt,
  input  logic signed [V_W-1:0]     in_vcnt,
  input  logic                      cfg_we,
  input  logic [LABEL_W-1:0]        cfg_idx,
  input  logic [CH_W-1:0]           cfg_thr,
  input  logic [LABEL_W-1:0]        hist_sel,
  output logic [LABEL_W-1:0]        out_y,
  output logic [H_W-1:0]            out_hcnt,
  output logic [V_W-1:0]            out_vcnt,
  output logic [CNT_W-1:0]          hist_cnt,
  output logic                      frame_done
);

  localparam int NUM_CLASS = 2**LABEL_W;
  localparam int SUM_W     = CH_W + 8;

  logic [CH_W-1:0]  thr_sh  [1:NUM_CLASS-1];
  logic [CH_W-1:0]  thr_act [1:NUM_CLASS-1];

  logic [SUM_W-1:0] sum;
  logic [CH_W-1:0]  luma;
  logic             in_sof;

  logic             s1_ok;
  logic [CH_W-1:0]  s1_luma;
  logic [H_W-1:0]   s1_h;
  logic [V_W-1:0]   s1_v;

  logic [LABEL_W-1:0] lbl;

  logic               s2_ok;
  logic [LABEL_W-1:0] s2_lbl;
  logic [H_W-1:0]     s2_h;
  logic [V_W-1:0]     s2_v;
  logic               s2_blank;
  logic               s2_sof;

  logic [CNT_W-1:0] live [NUM_CLASS];
  logic [CNT_W-1:0] snap [NUM_CLASS];
  logic             armed;

  // Weights sum to 256, so the shifted result always fits CH_W bits.
  always_comb begin
    sum = SUM_W'(77)  * SUM_W'(in_y[3*CH_W-1 -: CH_W])
        + SUM_W'(150) * SUM_W'(in_y[2*CH_W-1 -: CH_W])
        + SUM_W'(29)  * SUM_W'(in_y[CH_W-1:0]);
    luma = CH_W'(sum >> 8);
  end

  assign in_sof = (in_hcnt == '0) && (in_vcnt == '0);

  // Compare happens one edge after thr_act loads on (0,0), so the tail
  // of the previous frame still sees the old set.
  always_comb begin
    lbl = '0;
    for (int k = 1; k < NUM_CLASS; k++) begin
      if (s1_luma >= thr_act[k]) lbl = lbl + LABEL_W'(1);
    end
  end

  assign s2_blank = s2_h[H_W-1] | s2_v[V_W-1];
  assign s2_sof   = s2_ok && (s2_h == '0) && (s2_v == '0);

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 1; k < NUM_CLASS; k++) begin
        thr_sh[k]  <= CH_W'((k * (2**CH_W)) / NUM_CLASS);
        thr_act[k] <= CH_W'((k * (2**CH_W)) / NUM_CLASS);
      end
      s1_ok      <= 1'b0;
      s1_luma    <= '0;
      s1_h       <= '0;
      s1_v       <= '0;
      s2_ok      <= 1'b0;
      s2_lbl     <= '0;
      s2_h       <= '0;
      s2_v       <= '0;
      out_y      <= '0;
      out_hcnt   <= '0;
      out_vcnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      for (int k = 1; k < NUM_CLASS; k++) begin
        if (cfg_we && cfg_idx == LABEL_W'(k)) thr_sh[k] <= cfg_thr;
        if (in_sof) thr_act[k] <= thr_sh[k];
      end
      s1_ok      <= 1'b1;
      s1_luma    <= luma;
      s1_h       <= in_hcnt;
      s1_v       <= in_vcnt;
      s2_ok      <= s1_ok;
      s2_lbl     <= lbl;
      s2_h       <= s1_h;
      s2_v       <= s1_v;
      out_y      <= (s2_blank || !s2_ok) ? '0 : s2_lbl;
      out_hcnt   <= s2_h;
      out_vcnt   <= s2_v;
      frame_done <= s2_sof;
    end
  end

  // Counting starts at the first (0,0) after reset, so the first
  // snapshot is always empty.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        live[k] <= '0;
        snap[k] <= '0;
      end
      armed <= 1'b0;
    end else if (s2_sof) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        snap[k] <= live[k];
        live[k] <= (s2_lbl == LABEL_W'(k)) ? CNT_W'(1) : '0;
      end
      armed <= 1'b1;
    end else if (armed && s2_ok && !s2_blank) begin
      if (live[s2_lbl] != '1) live[s2_lbl] <= live[s2_lbl] + CNT_W'(1);
    end
  end

  assign hist_cnt = snap[hist_sel];

endmodule

// File: tb/tb_segment_labeler.sv
// tb_segment_labeler: directed checks of labeling, thresholds,
// histogram snapshot, saturation and reset.
module tb_segment_labeler;

  logic        clock;
  logic        n_rst;
  logic [23:0] in_y;
  logic signed [9:0] in_hcnt;
  logic signed [8:0] in_vcnt;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [7:0]  cfg_thr;
  logic [1:0]  hist_sel;

  logic [1:0]  out_y,    s_out_y;
  logic [9:0]  out_hcnt, s_out_hcnt;
  logic [8:0]  out_vcnt, s_out_vcnt;
  logic [19:0] hist_cnt;
  logic [3:0]  s_hist_cnt;
  logic        frame_done, s_frame_done;

  int passed = 0;
  int total  = 0;

  segment_labeler dut (
    .clock(clock), .n_rst(n_rst), .in_y(in_y),
    .in_hcnt(in_hcnt), .in_vcnt(in_vcnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_thr(cfg_thr),
    .hist_sel(hist_sel), .out_y(out_y),
    .out_hcnt(out_hcnt), .out_vcnt(out_vcnt),
    .hist_cnt(hist_cnt), .frame_done(frame_done)
  );

  segment_labeler #(.CNT_W(4)) dut_s (
    .clock(clock), .n_rst(n_rst), .in_y(in_y),
    .in_hcnt(in_hcnt), .in_vcnt(in_vcnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_thr(cfg_thr),
    .hist_sel(hist_sel), .out_y(s_out_y),
    .out_hcnt(s_out_hcnt), .out_vcnt(s_out_vcnt),
    .hist_cnt(s_hist_cnt), .frame_done(s_frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pix(input logic [23:0] y, input int h, input int v);
    in_y    = y;
    in_hcnt = 10'(h);
    in_vcnt = 9'(v);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pix(24'h000000, -1, -1);
  endtask

  task automatic hsel(input logic [1:0] s);
    hist_sel = s;
    #1;
  endtask

  initial begin
    n_rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_thr = '0;
    hist_sel = '0;
    idle(); idle();
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_hcnt", 32'(out_hcnt), 0);
    chk("rst_vcnt", 32'(out_vcnt), 0);
    chk("rst_hist", 32'(hist_cnt), 0);
    chk("rst_fd", 32'(frame_done), 0);
    n_rst = 1'b1;
    idle(); idle();

    // magenta: luma 105 -> class 1 with defaults
    pix(24'hFF00FF, 5, 5); idle(); idle();
    chk("mag_y", 32'(out_y), 1);
    chk("mag_h", 32'(out_hcnt), 5);
    chk("mag_v", 32'(out_vcnt), 5);

    // back-to-back
    pix(24'hFFFFFF, 6, 5);
    pix(24'h000000, 7, 5);
    pix(24'hFF00FF, 8, 5);
    chk("b2b_white", 32'(out_y), 3);
    idle();
    chk("b2b_black", 32'(out_y), 0);
    chk("b2b_black_h", 32'(out_hcnt), 7);
    idle();
    chk("b2b_mag", 32'(out_y), 1);
    chk("b2b_mag_h", 32'(out_hcnt), 8);

    // blanking
    pix(24'hFFFFFF, -1, 5); idle(); idle();
    chk("blank_y", 32'(out_y), 0);
    chk("blank_h", 32'(out_hcnt), 32'h3FF);
    chk("blank_v", 32'(out_vcnt), 5);

    // frame 1: first (0,0) after reset -> empty snapshot
    pix(24'hFFFFFF, 0, 0);
    pix(24'hFFFFFF, 1, 0);
    pix(24'hFFFFFF, 2, 0);
    chk("f1_fd", 32'(frame_done), 1);
    chk("f1_y", 32'(out_y), 3);
    hsel(2'd3);
    chk("f1_hist3", 32'(hist_cnt), 0);
    pix(24'hFFFFFF, 3, 0);
    chk("f1_fd_low", 32'(frame_done), 0);
    // frame 2 start
    pix(24'h000000, 0, 0);
    idle();
    chk("f1_fd_mid", 32'(frame_done), 0);
    idle();
    chk("f2_fd", 32'(frame_done), 1);
    chk("f2_y", 32'(out_y), 0);
    chk("f2_hist3", 32'(hist_cnt), 4);
    hsel(2'd0);
    chk("f2_hist0", 32'(hist_cnt), 0);
    hsel(2'd1);
    chk("f2_hist1", 32'(hist_cnt), 0);
    hsel(2'd2);
    chk("f2_hist2", 32'(hist_cnt), 0);
    idle();
    chk("f2_fd_low", 32'(frame_done), 0);

    // mid-frame threshold write stays in shadow
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_thr = 8'd200;
    idle();
    cfg_we = 1'b0;
    pix(24'hFF00FF, 1, 0); idle(); idle();
    chk("shadow_y", 32'(out_y), 1);

    // idx 0 writes are ignored
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_thr = 8'd0;
    idle();
    // frame 3: coincident write keeps old shadow for this frame
    cfg_idx = 2'd1; cfg_thr = 8'd10;
    pix(24'hFF00FF, 0, 0);
    cfg_we = 1'b0;
    idle(); idle();
    chk("f3_y", 32'(out_y), 0);
    chk("f3_fd", 32'(frame_done), 1);
    hsel(2'd0);
    chk("f3_hist0", 32'(hist_cnt), 1);
    hsel(2'd1);
    chk("f3_hist1", 32'(hist_cnt), 1);
    chk("f3_hist1_s", 32'(s_hist_cnt), 1);

    // frame 4: 20 black pixels
    for (int i = 0; i < 20; i++) pix(24'h000000, i, 0);
    // frame 5 start, threshold 10 now active
    pix(24'hFF00FF, 0, 0); idle(); idle();
    chk("f5_y", 32'(out_y), 1);
    chk("f5_fd", 32'(frame_done), 1);
    hsel(2'd0);
    chk("f4_hist0", 32'(hist_cnt), 20);
    chk("f4_hist0_sat", 32'(s_hist_cnt), 15);
    hsel(2'd1);
    chk("f4_hist1_s", 32'(s_hist_cnt), 0);
    hsel(2'd0);

    // reset mid-frame
    pix(24'hFFFFFF, 1, 0);
    pix(24'hFFFFFF, 2, 0);
    n_rst = 1'b0;
    #1;
    chk("mrst_y", 32'(out_y), 0);
    chk("mrst_h", 32'(out_hcnt), 0);
    chk("mrst_v", 32'(out_vcnt), 0);
    chk("mrst_fd", 32'(frame_done), 0);
    chk("mrst_hist", 32'(hist_cnt), 0);
    chk("mrst_hist_s", 32'(s_hist_cnt), 0);
    @(posedge clock);
    #1;
    n_rst = 1'b1;
    pix(24'hFFFFFF, 0, 0); idle(); idle();
    chk("prst_fd", 32'(frame_done), 1);
    chk("prst_y", 32'(out_y), 3);
    chk("prst_hist0", 32'(hist_cnt), 0);
    hsel(2'd3);
    chk("prst_hist3", 32'(hist_cnt), 0);
    idle();
    chk("prst_fd_low", 32'(frame_done), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
